// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, handshaked ALU with optional multi-cycle multiplier
//
// Accepts one operation per in_valid/in_ready handshake. Single-cycle ops
// register out/psw on the accept edge and pulse out_valid the following cycle.
// Arithmetic ops (ADD/ADC/SUB/SBC/INC/DEC/CMP) share one bw+1 bit adder;
// logic ops (AND/OR/XOR/NOT) are selected when sel[3]=1.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 4'b0110 is a shift-add multiply taking bw cycles in a
//               BUSY state (busy=1, in_ready=0), result = low half of product,
//               c = (high half != 0).
//   undefined : no multiplier or BUSY state; opcode 4'b0110 returns opa in one
//               cycle with psw unchanged; busy=0, in_ready=1 always.
//
// Ports
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle
//   sel[3:0]   opcode
//   opa, opb   operands (bw bits)
//   out_valid  one-cycle pulse: out/psw updated by a completed op
//   out        registered result (bw bits)
//   psw        registered flags {z,n,c,v}
//   busy       multi-cycle op in progress
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int bw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    sel,
    input  logic [bw-1:0] opa,
    input  logic [bw-1:0] opb,
    output logic          out_valid,
    output logic [bw-1:0] out,
    output logic [3:0]    psw,
    output logic          busy
);

    localparam logic [bw-1:0] one_c = {{(bw-1){1'b0}}, 1'b1};

    logic [bw-1:0] out_reg;
    logic [3:0]    psw_reg;
    logic          out_valid_reg;
    logic          accept;

    // ---------------------------------------------------------------- logic ops
    logic [bw-1:0] logic_res;
    logic [3:0]    logic_psw;

    genvar gi;
    generate
        for (gi = 0; gi < bw; gi++) begin : g_logic
            assign logic_res[gi] = (sel[2:1] == 2'b00) ? (opa[gi] & opb[gi]) :
                                   (sel[2:1] == 2'b01) ? (opa[gi] | opb[gi]) :
                                   (sel[2:1] == 2'b10) ? (opa[gi] ^ opb[gi]) :
                                                         ~opa[gi];
        end
    endgenerate

    assign logic_psw = {(logic_res == '0), logic_res[bw-1], 2'b00};

    // ----------------------------------------------------------- arithmetic ops
    // Every arithmetic op is a + addend + cin; subtraction inverts b and uses
    // the carry-in as the +1 (or psw.c for SBC), so c=1 means "no borrow".
    logic [bw-1:0] addend;
    logic          cin;
    logic [bw:0]   sum;
    logic [bw-1:0] arith_res;
    logic          arith_v;
    logic [3:0]    arith_psw;

    always_comb begin
        addend = opb;
        cin    = 1'b0;
        case (sel[2:0])
            3'b000: begin addend = opb;    cin = 1'b0;       end // ADD
            3'b001: begin addend = opb;    cin = psw_reg[1]; end // ADC
            3'b010: begin addend = ~opb;   cin = 1'b1;       end // SUB
            3'b011: begin addend = ~opb;   cin = psw_reg[1]; end // SBC
            3'b100: begin addend = one_c;  cin = 1'b0;       end // INC
            3'b101: begin addend = ~one_c; cin = 1'b1;       end // DEC
            3'b111: begin addend = ~opb;   cin = 1'b1;       end // CMP
            default: begin addend = opb;   cin = 1'b0;       end // MUL slot
        endcase
    end

    assign sum       = {1'b0, opa} + {1'b0, addend} + {{bw{1'b0}}, cin};
    assign arith_res = sum[bw-1:0];
    // Signed overflow: both adder inputs share a sign that the result lacks.
    assign arith_v   = (opa[bw-1] == addend[bw-1]) && (arith_res[bw-1] != opa[bw-1]);
    assign arith_psw = {(arith_res == '0), arith_res[bw-1], sum[bw], arith_v};

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------- multiplier
    localparam int cw = (bw > 1) ? $clog2(bw) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [2*bw-1:0] mcand_reg;
    logic [2*bw-1:0] prod_reg;
    logic [bw-1:0]   mplier_reg;
    logic [cw-1:0]   cnt_reg;
    logic [2*bw-1:0] prod_next;

    // Product including the partial product of the current step, so the last
    // step can write the result on the same edge it is formed.
    assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : {(2*bw){1'b0}});

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg == BUSY);
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    // ----------------------------------------------------------- state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            psw_reg       <= 4'b0000;
            out_valid_reg <= 1'b0;
`ifdef ALU_MUL_EN
            state_reg     <= IDLE;
            mcand_reg     <= '0;
            prod_reg      <= '0;
            mplier_reg    <= '0;
            cnt_reg       <= '0;
`endif
        end else begin
            out_valid_reg <= 1'b0;
`ifdef ALU_MUL_EN
            if (state_reg == BUSY) begin
                prod_reg   <= prod_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                if (cnt_reg == cw'(bw - 1)) begin
                    out_reg       <= prod_next[bw-1:0];
                    psw_reg       <= {(prod_next[bw-1:0] == '0), prod_next[bw-1],
                                      (prod_next[2*bw-1:bw] != '0), 1'b0};
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end else begin
                    cnt_reg <= cnt_reg + cw'(1);
                end
            end else
`endif
            if (accept) begin
                if (sel[3]) begin
                    out_reg       <= logic_res;
                    psw_reg       <= logic_psw;
                    out_valid_reg <= 1'b1;
                end else begin
                    case (sel[2:0])
                        3'b110: begin
`ifdef ALU_MUL_EN
                            mcand_reg  <= {{bw{1'b0}}, opa};
                            mplier_reg <= opb;
                            prod_reg   <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= BUSY;
`else
                            // No multiplier built: pass opa, keep flags.
                            out_reg       <= opa;
                            out_valid_reg <= 1'b1;
`endif
                        end
                        3'b111: begin
                            // CMP updates flags only.
                            psw_reg       <= arith_psw;
                            out_valid_reg <= 1'b1;
                        end
                        default: begin
                            out_reg       <= arith_res;
                            psw_reg       <= arith_psw;
                            out_valid_reg <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign out       = out_reg;
    assign psw       = psw_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    sel = 4'h0;
    logic [BW-1:0] opa = '0;
    logic [BW-1:0] opb = '0;
    logic          out_valid;
    logic [BW-1:0] out;
    logic [3:0]    psw;
    logic          busy;

    alu_seq #(.bw(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .opa       (opa),
        .opb       (opb),
        .out_valid (out_valid),
        .out       (out),
        .psw       (psw),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] out;
        logic [3:0]    psw;
        int            due;
    } exp_t;

    exp_t          scb[$];
    int            checks = 0;
    int            errors = 0;
    int            txn = 0;
    int            ready_cyc = 0;
    logic [BW-1:0] model_out = '0;
    logic [3:0]    model_psw = 4'b0000;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: computes results from the mathematical definition of
    // each operation (unsigned/signed integer arithmetic on wide values).
    function automatic void model(input logic [3:0] s, input logic [BW-1:0] a, input logic [BW-1:0] b,
                                  input logic [BW-1:0] o_in, input logic [3:0] p_in,
                                  output logic [BW-1:0] o, output logic [3:0] p, output int lat);
        longint m    = longint'(1) << BW;
        longint smax = m / 2 - 1;
        longint smin = -(m / 2);
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = a[BW-1] ? ua - m : ua;
        longint sb   = b[BW-1] ? ub - m : ub;
        longint r    = 0;
        longint sv   = 0;
        longint bor;
        logic   c    = 1'b0;
        logic [BW-1:0] res;
        o   = o_in;
        p   = p_in;
        lat = 1;
        if (s[3]) begin
            case (s[2:1])
                2'b00:   res = a & b;
                2'b01:   res = a | b;
                2'b10:   res = a ^ b;
                default: res = ~a;
            endcase
            o = res;
            p = {(res == 0), res[BW-1], 2'b00};
        end else if (s[2:0] == 3'b110) begin
`ifdef ALU_MUL_EN
            r   = ua * ub;
            res = r[BW-1:0];
            o   = res;
            p   = {(res == 0), res[BW-1], ((r >> BW) != 0), 1'b0};
            lat = BW + 1;
`else
            o = a;
`endif
        end else begin
            case (s[2:0])
                3'b000: begin r = ua + ub; c = (r >= m); sv = sa + sb; end
                3'b001: begin
                    r = ua + ub + longint'(p_in[1]); c = (r >= m); sv = sa + sb + longint'(p_in[1]);
                end
                3'b011: begin
                    bor = p_in[1] ? 0 : 1;
                    r = ua - ub - bor; c = (ua >= ub + bor); sv = sa - sb - bor;
                end
                3'b100: begin r = ua + 1; c = (r >= m); sv = sa + 1; end
                3'b101: begin r = ua - 1; c = (ua >= 1); sv = sa - 1; end
                default: begin r = ua - ub; c = (ua >= ub); sv = sa - sb; end // SUB, CMP
            endcase
            res = r[BW-1:0];
            p = {(res == 0), res[BW-1], c, ((sv > smax) || (sv < smin))};
            if (s[2:0] != 3'b111) o = res;
        end
    endfunction

    // Present one request for one edge. Acceptance follows the bench's own
    // expectation of readiness; the DUT's in_ready is checked by the monitor.
    task automatic do_op(input logic [3:0] s, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input bit use_exp, input logic [BW-1:0] eo, input logic [3:0] ep,
                         output bit acc);
        exp_t          e;
        logic [BW-1:0] mo;
        logic [3:0]    mp;
        int            lat;
        @(negedge clk);
        sel = s; opa = a; opb = b; in_valid = 1'b1;
        acc = (cyc >= ready_cyc);
        if (acc) begin
            model(s, a, b, model_out, model_psw, mo, mp, lat);
            if (use_exp) begin
                mo = eo;
                mp = ep;
            end
            model_out = mo;
            model_psw = mp;
            e.out = mo; e.psw = mp; e.due = cyc + lat;
            scb.push_back(e);
            if (lat > 1) ready_cyc = cyc + lat;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            opa = BW'($urandom);
            opb = BW'($urandom);
            sel = 4'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        scb.delete();
        ready_cyc = 0;
        model_out = '0;
        model_psw = 4'b0000;
        #1;
        chk("reset_out", 64'(out), 64'(0));
        chk("reset_psw", 64'(psw), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [BW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {1'b0, {(BW-1){1'b1}}};
            2:       return {1'b1, {(BW-1){1'b0}}};
            3:       return '1;
            default: return BW'($urandom);
        endcase
    endfunction

    // Monitor: checks handshake status every cycle and pops the scoreboard
    // whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                chk("in_ready", 64'(in_ready), 64'(cyc >= ready_cyc));
                chk("busy", 64'(busy), 64'(cyc < ready_cyc));
                if (out_valid) begin
                    if (scb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got out=0x%0h psw=%b expected no pulse (cycle %0d)",
                                 out, psw, cyc);
                    end else begin
                        e = scb.pop_front();
                        txn++;
                        $display("txn %0d: cycle %0d out=0x%0h psw=%b (expected out=0x%0h psw=%b)",
                                 txn, cyc, out, psw, e.out, e.psw);
                        chk("out", 64'(out), 64'(e.out));
                        chk("psw", 64'(psw), 64'(e.psw));
                        chk("latency_cycle", 64'(cyc), 64'(e.due));
                    end
                end else if (scb.size() != 0 && cyc >= scb[0].due) begin
                    e = scb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_out_valid: got no pulse expected out=0x%0h psw=%b at cycle %0d",
                             e.out, e.psw, e.due);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int tries;
        do_reset();

        // Directed cases with hand-derived expectations (bw = 8).
        do_op(4'b0000, 8'h7F, 8'h01, 1, 8'h80, 4'b0101, acc);   // ADD
        do_op(4'b0010, 8'h05, 8'h05, 1, 8'h00, 4'b1010, acc);   // SUB
        do_op(4'b0111, 8'h03, 8'h04, 1, 8'h00, 4'b0100, acc);   // CMP
        do_op(4'b0000, 8'hFF, 8'h01, 1, 8'h00, 4'b1010, acc);   // ADD
        do_op(4'b0001, 8'h00, 8'h00, 1, 8'h01, 4'b0000, acc);   // ADC
        do_op(4'b1110, 8'h0F, 8'h00, 1, 8'hF0, 4'b0100, acc);   // NOT
        do_op(4'b1000, 8'hF0, 8'h0F, 1, 8'h00, 4'b1000, acc);   // AND
        idle(2);
`ifdef ALU_MUL_EN
        do_op(4'b0110, 8'h10, 8'h20, 1, 8'h00, 4'b1010, acc);   // MUL
`else
        do_op(4'b0110, 8'h10, 8'h20, 1, 8'h10, 4'b1000, acc);   // passthrough
`endif
        // Requests presented while busy must be ignored.
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 40) begin
            do_op(4'b0000, 8'h01, 8'h01, 0, '0, '0, acc);
            tries++;
        end
        idle(3);

        // Reset in the middle of a multiply (or after a plain op without one).
        do_op(4'b0110, 8'hAB, 8'hCD, 0, '0, '0, acc);
        idle(3);
        do_reset();
        idle(BW + 4);

        // Randomized traffic with gaps and requests during busy periods.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else do_op(4'($urandom), pick_operand(), pick_operand(), 0, '0, '0, acc);
        end
        idle(BW + 6);
        chk("scoreboard_empty", 64'(scb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the team's combinational 8-bit ALU; generalised in width, with multi-cycle multiply, carry-chained ops (ADC/SBC), a flags-only compare, and a persistent PSW register.
- Sits between the operand register file and the writeback path of the fib datapath.
- Accepts one operation per valid/ready handshake and presents a registered result plus {z,n,c,v} flags.

Parameters:
- bw, 8, operand/result width in bits (>=4).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- sel  in  4  opcode (encoding below)
- opa  in  bw  operand A
- opb  in  bw  operand B
- out_valid  out  1  one-cycle pulse: out/psw updated by a completed op
- out  out  bw  registered result
- psw  out  4  registered flags {z,n,c,v}
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, psw=4'b0000, out_valid=0, busy=0, in_ready=1. Reset mid-multiply aborts it; no out_valid follows.
- Accept: in_valid & in_ready on a rising edge. in_ready = (state==IDLE). Requests while not ready are ignored, not queued.
- Opcodes, sel[3]=1 (logic): sel[2:1] selects 00 AND, 01 OR, 10 XOR, 11 NOT opa. sel[0] is ignored. Flags: z and n from the logic result; c=0, v=0.
- Opcodes, sel[3]=0 (arith), by sel[2:0]:
  - 000 ADD a+b
  - 001 ADC a+b+psw.c
  - 010 SUB a-b
  - 011 SBC a-b-!psw.c
  - 100 INC a+1
  - 101 DEC a-1
  - 110 MUL
  - 111 CMP a-b
- Subtraction is computed as a+~b+1 (SBC: a+~b+psw.c). c = carry out of bit bw-1, so c=1 means no borrow.
- v = signed overflow of the bw-bit two's-complement operation.
- z = (result==0); n = result[bw-1]. All flags derive from the actual result, never from a non-selected path.
- CMP: psw updated, out holds its previous value, out_valid still pulses.
- Single-cycle ops: out/psw registered on the accept edge; out_valid high for the following cycle; in_ready stays 1, so back-to-back ops run at one per cycle.
- MUL: FSM IDLE -> BUSY on accept; shift-add with one partial-product step per cycle for bw cycles; busy=1 and in_ready=0 throughout. The last step's edge writes out = low bw bits of the 2bw-bit product and returns the FSM to IDLE. out_valid is high in the cycle after that edge, i.e. bw+1 cycles after accept.
- MUL flags: z,n from the low half; c = (high half != 0); v=0.
- Operands are captured at accept; opa/opb/sel changes during BUSY have no effect.
- ADC/SBC use psw.c as registered at the accept edge, which includes the result of the op completed on the previous edge.
- out_valid never asserts for two ops in the same cycle; there is no output backpressure (consumer must take the pulse).

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 0110 is MUL as above; busy/BUSY state exist.
- Undefined: no multiplier or BUSY state is built; busy tied 0; in_ready tied 1. Opcode 0110 completes in one cycle with out=opa and psw unchanged; out_valid still pulses.

Test Plan:
- Reset then ADD 0x7F+0x01 (bw=8) -> next cycle out_valid=1, out=0x80, psw=4'b0101.
- SUB 0x05-0x05 -> out=0x00, psw=4'b1010; then CMP 0x03,0x04 -> out stays 0x00, psw=4'b0100 (borrow: c=0).
- ADD 0xFF+0x01 -> out=0x00, psw=4'b1010; immediately ADC 0x00+0x00 -> out=0x01, psw=4'b0000. Back-to-back, in_ready held 1.
- NOT 0x0F (sel=4'b1110) -> out=0xF0, psw=4'b0100; AND 0xF0&0x0F -> out=0x00, psw=4'b1000.
- With ALU_MUL_EN: MUL 0x10*0x20 -> in_ready=0 and busy=1 for 8 cycles; out_valid 9 cycles after accept; out=0x00, psw=4'b1010. A request with in_valid=1 during BUSY is ignored.
- Assert rst_n=0 at the 4th cycle of a MUL -> out=0, psw=0, busy=0, in_ready=1 immediately; no out_valid pulse after release.
